fir_coef_arbiter: RTL and testbench
===================================

FIR_COEF_ARBITER -- requirements
Module: fir_coef_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_TAPS, default 10, the number of coefficients in one full load.
REQ-002 The block SHALL have parameter COEF_W, default 8, the coefficient width.
REQ-003 The block SHALL have parameter IDX_W, default 4, the coefficient index width.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have the port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have the ports req0 and req1, input, 1 bit each: requester n asks to load a full coefficient set.
REQ-007 The block SHALL have the ports gnt0 and gnt1, output, 1 bit each: requester n owns the coefficient port.
REQ-008 The block SHALL have the ports valid0 and valid1, input, 1 bit each: requester n presents a coefficient word.
REQ-009 The block SHALL have the ports data0 and data1, input, COEF_W bits each: the coefficient word from requester n.
REQ-010 The block SHALL have the ports ready0 and ready1, output, 1 bit each: the block accepts a word from requester n.
REQ-011 The block SHALL have the port coef_write_enable, output, 1 bit: the write strobe to the FIR filter.
REQ-012 The block SHALL have the port coef_number, output, IDX_W bits: the tap index being written.
REQ-013 The block SHALL have the port coef_value, output, COEF_W bits: the coefficient being written.
REQ-014 The block SHALL have the port filter_hold, output, 1 bit: FIR outputs are invalid while coefficients change.
REQ-015 The block SHALL have the port load_done, output, 1 bit: one-cycle pulse when a full set has been written.
REQ-016 The block SHALL have the port load_abort, output, 1 bit: one-cycle pulse when a load is abandoned.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD and DONE, and every output SHALL be registered.
REQ-018 In IDLE, if req0 or req1 is high, the FSM SHALL assert the grant for the selected requester on the next edge and enter LOAD.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted most recently wins. After reset, requester 0 has priority.
REQ-020 In LOAD, ready is high only for the granted requester. A beat is accepted when valid and ready are both high.
REQ-021 On an accepted beat at tap counter k, the next cycle SHALL have coef_write_enable=1, coef_number=k and coef_value=data; the counter then increments.
REQ-022 The write latency SHALL be exactly one cycle from acceptance to the strobe, with no gaps imposed by the block; back-to-back beats are allowed.
REQ-023 When no beat is accepted, coef_write_enable SHALL be 0, and coef_number and coef_value SHALL hold their last values.
REQ-024 valid and data from a non-granted requester SHALL be ignored and never written.
REQ-025 The beat accepted at k=NUM_TAPS-1 SHALL move the FSM to DONE.
REQ-026 In DONE, for one cycle: load_done=1, the grant drops, the round-robin pointer records the winner, and the FSM returns to IDLE.
REQ-027 If the granted requester drops req in LOAD before the last beat, the block SHALL make no further writes, pulse load_abort for one cycle, drop the grant, update the pointer and return to IDLE. Taps already written stay written.
REQ-028 If req drops in the same cycle as the last accepted beat, the beat SHALL complete normally with DONE, not abort.
REQ-029 filter_hold SHALL be 1 in LOAD and DONE, and also during the final write-strobe cycle; it is 0 otherwise.
REQ-030 A new grant SHALL NOT be issued in the DONE or abort cycle; the earliest new grant is the cycle after IDLE is re-entered.
REQ-031 The tap counter SHALL be IDX_W bits and reset to 0 at the start of each grant; it never wraps within a load.

Reset
REQ-032 While rst=1, the block SHALL force the FSM to IDLE, the counter to 0 and the pointer to requester 0.
REQ-033 While rst=1, gnt, ready, coef_write_enable, coef_number, coef_value, filter_hold, load_done and load_abort SHALL all be 0.
REQ-034 Reset asserted mid-LOAD SHALL abandon the load immediately with no load_abort pulse and no further write.

Verification
REQ-035 Single load: req0=1, valid0 held high with data 1..10 -> gnt0 after 1 cycle; 10 strobes with coef_number 0..9 and coef_value 1..10; then load_done pulses once and gnt0 drops.
REQ-036 Contention: req0 and req1 both high from reset -> requester 0 loads first and requester 1 loads next; when both request again, requester 0 is served after requester 1.
REQ-037 Throttled: valid1 high every other cycle -> the strobes are spaced 2 cycles apart, indices stay contiguous 0..9, and data from requester 0 is never written.
REQ-038 Abort: req0 drops after 4 accepted beats -> taps 0..3 are written, load_abort pulses once, there is no load_done, and a pending req1 is granted 2 cycles later.
REQ-039 Reset mid-load: rst pulsed after 5 beats -> all outputs 0 while reset is high; after release, req1 with req0 both high -> gnt0 first.

Source files
------------

// File: rtl/fir_coef_arbiter.sv
// Round-robin arbiter that lets one of two requesters stream a full FIR coefficient
// set into the filter's coefficient port, with hold, done and abort signalling.
module fir_coef_arbiter #(
  parameter int NUM_TAPS = 10,
  parameter int COEF_W   = 8,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              valid0,
  input  logic              valid1,
  input  logic [COEF_W-1:0] data0,
  input  logic [COEF_W-1:0] data1,
  output logic              ready0,
  output logic              ready1,
  output logic              coef_write_enable,
  output logic [IDX_W-1:0]  coef_number,
  output logic [COEF_W-1:0] coef_value,
  output logic              filter_hold,
  output logic              load_done,
  output logic              load_abort
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic [IDX_W-1:0]    tap_q, tap_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          ready_q, ready_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    num_q, num_d;
  logic [COEF_W-1:0]   val_q, val_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;

  logic                req_sel_s;
  logic                valid_sel_s;
  logic                ready_sel_s;
  logic [COEF_W-1:0]   data_sel_s;
  logic                accept_s;
  logic                last_s;

  // Everything below looks only at the current owner; the other requester is invisible.
  assign req_sel_s   = owner_q ? req1 : req0;
  assign valid_sel_s = owner_q ? valid1 : valid0;
  assign ready_sel_s = owner_q ? ready_q[1] : ready_q[0];
  assign data_sel_s  = owner_q ? data1 : data0;
  assign accept_s    = (state_q == ST_LOAD) && valid_sel_s && ready_sel_s;
  assign last_s      = (tap_q == LAST_TAP);

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    tap_d   = tap_q;
    we_d    = 1'b0;
    num_d   = num_q;
    val_d   = val_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_LOAD;
          tap_d   = {IDX_W{1'b0}};
          if (req0 && req1) begin
            owner_d = prio_q;
          end else if (req1) begin
            owner_d = 1'b1;
          end else begin
            owner_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A final beat wins over a simultaneous request drop.
        if (accept_s && last_s) begin
          we_d    = 1'b1;
          num_d   = tap_q;
          val_d   = data_sel_s;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (!req_sel_s) begin
          abort_d = 1'b1;
          prio_d  = ~owner_q;
          state_d = ST_IDLE;
        end else if (accept_s) begin
          we_d  = 1'b1;
          num_d = tap_q;
          val_d = data_sel_s;
          tap_d = tap_q + IDX_W'(1);
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        prio_d  = ~owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_LOAD) begin
      gnt_d = owner_d ? 2'b10 : 2'b01;
    end else begin
      gnt_d = 2'b00;
    end
    ready_d = gnt_d;
    hold_d  = (state_d == ST_LOAD) || (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      tap_q   <= {IDX_W{1'b0}};
      gnt_q   <= 2'b00;
      ready_q <= 2'b00;
      we_q    <= 1'b0;
      num_q   <= {IDX_W{1'b0}};
      val_q   <= {COEF_W{1'b0}};
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      tap_q   <= tap_d;
      gnt_q   <= gnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      num_q   <= num_d;
      val_q   <= val_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign gnt0              = gnt_q[0];
  assign gnt1              = gnt_q[1];
  assign ready0            = ready_q[0];
  assign ready1            = ready_q[1];
  assign coef_write_enable = we_q;
  assign coef_number       = num_q;
  assign coef_value        = val_q;
  assign filter_hold       = hold_q;
  assign load_done         = done_q;
  assign load_abort        = abort_q;

endmodule

// File: tb/tb_fir_coef_arbiter.sv
// Scoreboard bench: a transaction-level model queues expected writes/done/abort
// events with their cycle stamps; a negedge monitor pops and compares them.
module tb_fir_coef_arbiter;
  localparam int NT = 10;
  localparam int CW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
  logic [CW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1, ready0, ready1, coef_write_enable;
  logic [IW-1:0] coef_number;
  logic [CW-1:0] coef_value;
  logic          filter_hold, load_done, load_abort;

  always #5 clk = ~clk;

  fir_coef_arbiter #(.NUM_TAPS(NT), .COEF_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .ready0(ready0), .ready1(ready1), .coef_write_enable(coef_write_enable),
    .coef_number(coef_number), .coef_value(coef_value), .filter_hold(filter_hold),
    .load_done(load_done), .load_abort(load_abort)
  );

  typedef struct { int stamp; int num; int val; } wr_t;
  wr_t wq[$];
  int  dq[$];
  int  aq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state
  bit m_load = 0, m_fin = 0;
  int m_own = 0, m_prio = 0, m_cnt = 0;
  bit exp_g0 = 0, exp_g1 = 0, exp_hold = 0;
  bit seq_data = 0;
  int last_num = 0, last_val = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic m_reset();
    m_load = 0; m_fin = 0; m_own = 0; m_prio = 0; m_cnt = 0;
    exp_g0 = 0; exp_g1 = 0; exp_hold = 0;
    wq.delete(); dq.delete(); aq.delete();
  endtask

  // One clock edge of the reference: what the filter should see in the following cycle.
  task automatic model_step();
    bit o_req, o_val;
    int o_dat;
    wr_t w;
    cyc++;
    if (rst) begin
      m_reset();
      return;
    end
    if (m_load) begin
      o_req = (m_own == 1) ? req1 : req0;
      o_val = (m_own == 1) ? valid1 : valid0;
      o_dat = (m_own == 1) ? int'(data1) : int'(data0);
      if (o_val && m_cnt == NT - 1) begin
        w.stamp = cyc; w.num = m_cnt; w.val = o_dat;
        wq.push_back(w);
        dq.push_back(cyc);
        m_load = 0; m_fin = 1;
      end else if (!o_req) begin
        aq.push_back(cyc);
        m_load = 0; m_prio = 1 - m_own;
      end else if (o_val) begin
        w.stamp = cyc; w.num = m_cnt; w.val = o_dat;
        wq.push_back(w);
        m_cnt++;
      end
    end else if (m_fin) begin
      m_fin = 0; m_prio = 1 - m_own;
    end else if (req0 || req1) begin
      m_own  = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
      m_load = 1; m_cnt = 0;
    end
    exp_g0   = m_load && (m_own == 0);
    exp_g1   = m_load && (m_own == 1);
    exp_hold = m_load || m_fin;
  endtask

  task automatic step(input bit r0, input bit r1, input bit v0, input bit v1, input bit rs);
    @(posedge clk);
    model_step();
    #1;
    req0 = r0; req1 = r1; valid0 = v0; valid1 = v1;
    data0 = (seq_data && m_load && m_own == 0) ? CW'(m_cnt + 1) : CW'($urandom);
    data1 = CW'($urandom);
    if (rs && !rst) begin
      rst = 1'b1;
      m_reset();
    end else begin
      rst = rs;
    end
  endtask

  // Monitor: per-cycle grant/hold checks plus in-order event scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin last_num = 0; last_val = 0; end
      chk("gnt0", int'(gnt0), int'(exp_g0));
      chk("gnt1", int'(gnt1), int'(exp_g1));
      chk("ready0", int'(ready0), int'(exp_g0));
      chk("ready1", int'(ready1), int'(exp_g1));
      chk("filter_hold", int'(filter_hold), int'(exp_hold));
      if (coef_write_enable) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          e = wq.pop_front();
          chk("write_cycle", cyc, e.stamp);
          chk("coef_number", int'(coef_number), e.num);
          chk("coef_value", int'(coef_value), e.val);
          last_num = e.num; last_val = e.val;
        end
      end else begin
        if (wq.size() > 0 && wq[0].stamp <= cyc) begin
          void'(wq.pop_front());
          chk("write_missing", 0, 1);
        end
        chk("coef_number_hold", int'(coef_number), last_num);
        chk("coef_value_hold", int'(coef_value), last_val);
      end
      if (load_done) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, dq.pop_front());
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        void'(dq.pop_front());
        chk("done_missing", 0, 1);
      end
      if (load_abort) begin
        if (aq.size() == 0) chk("abort_unexpected", 1, 0);
        else chk("abort_cycle", cyc, aq.pop_front());
      end else if (aq.size() > 0 && aq[0] <= cyc) begin
        void'(aq.pop_front());
        chk("abort_missing", 0, 1);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    bit r0, r1;
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // single load with data 1..NT
    seq_data = 1;
    for (int i = 0; i < 13; i++) step(1, 0, 1, 0, 0);
    seq_data = 0;
    repeat (4) step(0, 0, 0, 0, 0);
    // contention from reset
    repeat (2) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 1, 1, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // throttled requester 1, requester 0 valid noise
    for (int i = 0; i < 26; i++) step(0, 1, 1, (i % 2) == 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // abort after 4 beats with requester 1 pending
    repeat (2) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20 && !(m_load && m_own == 0 && m_cnt == 4); i++) step(1, m_load, 1, 0, 0);
    chk("abort_setup", int'(m_load && m_cnt == 4), 1);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // reset mid-load after 5 beats
    for (int i = 0; i < 20 && !(m_load && m_cnt == 5); i++) step(1, 0, 1, 0, 0);
    chk("reset_setup", int'(m_load && m_cnt == 5), 1);
    repeat (2) step(1, 0, 1, 0, 1);
    for (int i = 0; i < 14; i++) step(1, 1, 1, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    // randomized traffic
    r0 = 0; r1 = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) < 6) r0 = ~r0;
      if ($urandom_range(99) < 6) r1 = ~r1;
      step(r0, r1, $urandom_range(99) < 70, $urandom_range(99) < 70, $urandom_range(999) < 3);
    end
    repeat (20) step(0, 0, 0, 0, 0);
    chk("writes_pending", wq.size(), 0);
    chk("done_pending", dq.size(), 0);
    chk("abort_pending", aq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
